// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier
//   Sequential two's-complement add-shift multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   The product is held in {X, A, B}. One multiplier bit is retired per COMPUTE cycle.
//   When the MSB (sign bit) of the multiplier is 1, the multiplicand is subtracted on the
//   final step instead of added.
//
//   Optional feature: define MULT_OVF_EN to add the Ovf port and its overflow logic.
//
//   Ports
//     Clk           clock, all state on posedge
//     Reset         synchronous active-high reset
//     ClearA_LoadB  in IDLE: A <= 0, X <= 0, B <= S
//     Run           a rising level in IDLE starts a multiply
//     S             switch operand (B on load, multiplicand on start)
//     X             sign-extension bit of A
//     Aval / Bval   upper / lower product halves
//     Busy          high in CLEAR and COMPUTE
//     Done          high in HOLD
//     Ovf           (MULT_OVF_EN only) product not representable in WIDTH bits signed
module seq_signed_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic             X,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Busy,
  output logic             Done
`ifdef MULT_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StClear, StCompute, StHold} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic              x_q, x_d;
  logic [CntW-1:0]   count_q, count_d;
  // Set once Run has been seen low. A start requires it, so a Run level that is
  // still held after Reset or after HOLD cannot launch a second multiply.
  logic              armed_q, armed_d;

  logic              last_bit;
  logic [WIDTH:0]    xa, m_ext, sum;

  assign last_bit = (count_q == CntW'(WIDTH - 1));
  assign xa       = {x_q, a_q};
  assign m_ext    = {m_q[WIDTH-1], m_q};

  // WIDTH+1-bit signed partial sum; the final multiplier bit carries negative weight.
  always_comb begin
    sum = xa;
    if (b_q[0]) begin
      if (last_bit) sum = xa - m_ext;
      else          sum = xa + m_ext;
    end
  end

`ifdef MULT_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    count_d = count_q;
    armed_d = Run ? armed_q : 1'b1;
`ifdef MULT_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (Run && armed_q) begin
          state_d = StClear;
          armed_d = 1'b0;
        end else if (ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
`ifdef MULT_OVF_EN
          ovf_d = 1'b0;
`endif
        end
      end
      StClear: begin
        m_d     = S;
        a_d     = '0;
        x_d     = 1'b0;
        count_d = '0;
        state_d = StCompute;
`ifdef MULT_OVF_EN
        ovf_d   = 1'b0;
`endif
      end
      StCompute: begin
        // Arithmetic shift right of {sum, B}; the sum's sign becomes the new X.
        x_d     = sum[WIDTH];
        a_d     = sum[WIDTH:1];
        b_d     = {sum[0], b_q[WIDTH-1:1]};
        count_d = count_q + CntW'(1);
        if (last_bit) begin
          state_d = StHold;
`ifdef MULT_OVF_EN
          // Upper half must be a pure sign extension of the lower half's MSB.
          ovf_d = (sum[WIDTH:1] != {WIDTH{sum[0]}});
`endif
        end
      end
      StHold: begin
        if (!Run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

`ifdef MULT_OVF_EN
  always_ff @(posedge Clk) begin
    if (Reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign Ovf = ovf_q;
`endif

  assign X    = x_q;
  assign Aval = a_q;
  assign Bval = b_q;
  assign Busy = (state_q == StClear) || (state_q == StCompute);
  assign Done = (state_q == StHold);

endmodule
